// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative shift-add MUL
// and optional restoring DIV (compiled in only when SEQ_ALU_DIV_EN is defined).
module seq_alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] a_operand,
  input  logic [WIDTH-1:0] b_operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Output,
  output logic             Exception,
  output logic             Overflow,
  output logic             busy
);

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_LS  = 4'd9;
  localparam logic [3:0] OP_RS  = 4'd10;
  localparam int         CW     = $clog2(WIDTH);

`ifdef SEQ_ALU_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1} state_t;
`endif

  state_t           r_state;
  state_t           w_nextState;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_a;
  logic             r_outValid;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             r_ovf;

  logic             w_accept;
  logic             w_lastIter;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH-1:0] w_result;
  logic             w_exc;
  logic             w_ovf;
  logic             w_isMul;
  logic             w_isDiv;

  assign in_ready   = (r_state == IDLE) && (!r_outValid || out_ready);
  assign busy       = (r_state != IDLE);
  assign out_valid  = r_outValid;
  assign ALU_Output = r_result;
  assign Exception  = r_exc;
  assign Overflow   = r_ovf;

  assign w_accept   = in_valid && in_ready;
  assign w_lastIter = (r_count == CW'(WIDTH - 1));
  assign w_sum      = {1'b0, a_operand} + {1'b0, b_operand};
  // Product sits in {r_hi, r_lo}; multiplier bits retire from the bottom of r_lo.
  assign w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   w_remShift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_remNext;

  assign w_remShift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff     = w_remShift - {1'b0, r_b};
  assign w_borrow   = w_diff[WIDTH];
  assign w_remNext  = w_borrow ? w_remShift[WIDTH-1:0] : w_diff[WIDTH-1:0];
`endif

  always_comb begin
    w_result = '0;
    w_exc    = 1'b0;
    w_ovf    = 1'b0;
    w_isMul  = 1'b0;
    w_isDiv  = 1'b0;
    case (Operation)
      OP_ADD: begin w_result = w_sum[WIDTH-1:0]; w_ovf = w_sum[WIDTH]; end
      OP_SUB: begin w_result = a_operand - b_operand; w_ovf = (a_operand < b_operand); end
      OP_MUL: w_isMul = 1'b1;
`ifdef SEQ_ALU_DIV_EN
      OP_DIV: begin
        if (b_operand == '0) begin
          w_result = '1;
          w_exc    = 1'b1;
        end else begin
          w_isDiv  = 1'b1;
        end
      end
`endif
      OP_AND: w_result = a_operand & b_operand;
      OP_OR:  w_result = a_operand | b_operand;
      OP_XOR: w_result = a_operand ^ b_operand;
      OP_NOT: w_result = ~a_operand;
      OP_LS:  begin w_result = {a_operand[WIDTH-2:0], 1'b0}; w_ovf = a_operand[WIDTH-1]; end
      OP_RS:  begin w_result = {1'b0, a_operand[WIDTH-1:1]}; w_ovf = a_operand[0]; end
      default: w_exc = 1'b1;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_isMul) w_nextState = MUL;
`ifdef SEQ_ALU_DIV_EN
        else if (w_accept && w_isDiv) w_nextState = DIV;
`endif
      end
      MUL: if (w_lastIter) w_nextState = IDLE;
`ifdef SEQ_ALU_DIV_EN
      DIV: if (w_lastIter) w_nextState = IDLE;
`endif
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_a        <= '0;
`ifdef SEQ_ALU_DIV_EN
      r_b        <= '0;
`endif
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_exc      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_count <= '0;
            r_hi    <= '0;
            r_a     <= a_operand;
            r_lo    <= w_isMul ? b_operand : a_operand;
`ifdef SEQ_ALU_DIV_EN
            r_b     <= b_operand;
`endif
            if (w_isMul || w_isDiv) begin
              r_outValid <= 1'b0;
            end else begin
              r_result   <= w_result;
              r_exc      <= w_exc;
              r_ovf      <= w_ovf;
              r_outValid <= 1'b1;
            end
          end else if (out_ready) begin
            r_outValid <= 1'b0;
          end
        end
        MUL: begin
          r_count <= r_count + CW'(1);
          r_hi    <= w_mulSum[WIDTH:1];
          r_lo    <= {w_mulSum[0], r_lo[WIDTH-1:1]};
          if (w_lastIter) begin
            r_result   <= {w_mulSum[0], r_lo[WIDTH-1:1]};
            r_ovf      <= |w_mulSum[WIDTH:1];
            r_exc      <= 1'b0;
            r_outValid <= 1'b1;
          end
        end
`ifdef SEQ_ALU_DIV_EN
        // Dividend shifts out of r_lo's top while quotient bits shift in at the bottom.
        DIV: begin
          r_count <= r_count + CW'(1);
          r_hi    <= w_remNext;
          r_lo    <= {r_lo[WIDTH-2:0], ~w_borrow};
          if (w_lastIter) begin
            r_result   <= {r_lo[WIDTH-2:0], ~w_borrow};
            r_ovf      <= 1'b0;
            r_exc      <= 1'b0;
            r_outValid <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed vector table, random ops
// against an arithmetic reference model, and hand-written handshake/reset sequences.
module tb_seq_alu;

  localparam int W = 8;
`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   Operation;
  logic [W-1:0] a_operand;
  logic [W-1:0] b_operand;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU_Output;
  logic         Exception;
  logic         Overflow;
  logic         busy;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expRes;
    logic         expExc;
    logic         expOvf;
    int           expLat;
  } vec_t;

  vec_t table_v[17];

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .a_operand(a_operand), .b_operand(b_operand),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_Output(ALU_Output),
    .Exception(Exception), .Overflow(Overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Expected behaviour straight from the operation definitions, in integer arithmetic.
  function automatic void refModel(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] res, output logic exc, output logic ovf,
                                   output int lat);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    r = 0; exc = 1'b0; ovf = 1'b0; lat = 0;
    case (op)
      4'd1: begin r = ia + ib; ovf = (r > 255); end
      4'd2: begin r = ia - ib + 256; ovf = (ia < ib); end
      4'd3: begin r = ia * ib; ovf = (r >= 256); lat = W; end
      4'd4: begin
        if (!DIV_EN) exc = 1'b1;
        else if (ib == 0) begin r = 255; exc = 1'b1; end
        else begin r = ia / ib; lat = W; end
      end
      4'd5: r = ia & ib;
      4'd6: r = ia | ib;
      4'd7: r = ia ^ ib;
      4'd8: r = 255 - ia;
      4'd9: begin r = ia * 2; ovf = (ia >= 128); end
      4'd10: begin r = ia / 2; ovf = (ia % 2 == 1); end
      default: exc = 1'b1;
    endcase
    res = W'(r % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, waits for its result with garbage requests pending, checks, consumes.
  task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] expRes,
                               input logic expExc, input logic expOvf, input int expLat);
    int waited;
    out_ready = 1'b0;
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
    Operation = op; a_operand = a; b_operand = b; in_valid = 1'b1;
    tick();
    waited = 0;
    while (!out_valid && waited < W + 4) begin
      checkOutput({tag, " busy"}, 32'(busy), 32'd1);
      checkOutput({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
      Operation = 4'($urandom); a_operand = W'($urandom); b_operand = W'($urandom);
      tick();
      waited++;
    end
    checkOutput({tag, " latency"}, 32'(waited), 32'(expLat));
    checkOutput({tag, " result"}, 32'(ALU_Output), 32'(expRes));
    checkOutput({tag, " exception"}, 32'(Exception), 32'(expExc));
    checkOutput({tag, " overflow"}, 32'(Overflow), 32'(expOvf));
    checkOutput({tag, " in_ready held"}, 32'(in_ready), 32'd0);
    tick();
    checkOutput({tag, " result held"}, 32'(ALU_Output), 32'(expRes));
    checkOutput({tag, " valid held"}, 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, " consumed"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [W-1:0] rRes;
    logic         rExc, rOvf;
    int           rLat;
    logic [3:0]   op;
    logic [W-1:0] a, b;

    table_v[0]  = '{4'd1,  8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 0};
    table_v[1]  = '{4'd2,  8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 0};
    table_v[2]  = '{4'd2,  8'h07, 8'h05, 8'h02, 1'b0, 1'b0, 0};
    table_v[3]  = '{4'd3,  8'h10, 8'h20, 8'h00, 1'b0, 1'b1, W};
    table_v[4]  = '{4'd3,  8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, W};
    table_v[5]  = '{4'd3,  8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, W};
`ifdef SEQ_ALU_DIV_EN
    table_v[6]  = '{4'd4,  8'hC8, 8'h07, 8'h1C, 1'b0, 1'b0, W};
    table_v[7]  = '{4'd4,  8'h05, 8'h00, 8'hFF, 1'b1, 1'b0, 0};
    table_v[8]  = '{4'd4,  8'hFF, 8'h01, 8'hFF, 1'b0, 1'b0, W};
`else
    table_v[6]  = '{4'd4,  8'hC8, 8'h07, 8'h00, 1'b1, 1'b0, 0};
    table_v[7]  = '{4'd4,  8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 0};
    table_v[8]  = '{4'd4,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0};
`endif
    table_v[9]  = '{4'd5,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 0};
    table_v[10] = '{4'd6,  8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 0};
    table_v[11] = '{4'd7,  8'hAA, 8'h0F, 8'hA5, 1'b0, 1'b0, 0};
    table_v[12] = '{4'd8,  8'h0F, 8'h55, 8'hF0, 1'b0, 1'b0, 0};
    table_v[13] = '{4'd9,  8'h81, 8'h00, 8'h02, 1'b0, 1'b1, 0};
    table_v[14] = '{4'd10, 8'h81, 8'h00, 8'h40, 1'b0, 1'b1, 0};
    table_v[15] = '{4'd0,  8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 0};
    table_v[16] = '{4'd15, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 0};

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Operation = 4'd0; a_operand = '0; b_operand = '0;
    #12;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset ALU_Output", 32'(ALU_Output), 32'd0);
    checkOutput("reset Exception", 32'(Exception), 32'd0);
    checkOutput("reset Overflow", 32'(Overflow), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("release in_ready", 32'(in_ready), 32'd1);
    tick();

    for (int i = 0; i < 17; i++)
      applyStimulus($sformatf("vec%0d", i), table_v[i].op, table_v[i].a, table_v[i].b,
                    table_v[i].expRes, table_v[i].expExc, table_v[i].expOvf, table_v[i].expLat);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = W'($urandom);
      b  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      refModel(op, a, b, rRes, rExc, rOvf, rLat);
      applyStimulus($sformatf("rnd%0d op%0d", i, op), op, a, b, rRes, rExc, rOvf, rLat);
    end

    // Stalled XOR result, then consume-and-accept NOT, then consume-and-accept MUL.
    out_ready = 1'b0;
    Operation = 4'd7; a_operand = 8'hAA; b_operand = 8'h0F; in_valid = 1'b1;
    tick();
    Operation = 4'd8; a_operand = 8'h0F; b_operand = 8'h00;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall%0d result", i), 32'(ALU_Output), 32'hA5);
      checkOutput($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("b2b in_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("b2b valid", 32'(out_valid), 32'd1);
    checkOutput("b2b result", 32'(ALU_Output), 32'hF0);
    checkOutput("b2b exception", 32'(Exception), 32'd0);
    Operation = 4'd3; a_operand = 8'h03; b_operand = 8'h05;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("b2b mul valid cleared", 32'(out_valid), 32'd0);
    checkOutput("b2b mul busy", 32'(busy), 32'd1);
    repeat (W) tick();
    checkOutput("b2b mul valid", 32'(out_valid), 32'd1);
    checkOutput("b2b mul result", 32'(ALU_Output), 32'h0F);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("b2b mul consumed", 32'(out_valid), 32'd0);

    // Abort a multiply with reset during its fourth iteration.
    Operation = 4'd3; a_operand = 8'h12; b_operand = 8'h34; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    checkOutput("abort busy before", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort ALU_Output", 32'(ALU_Output), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < W + 4; i++) begin
      tick();
      checkOutput($sformatf("abort quiet%0d", i), 32'({out_valid, busy}), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width in bits; legal values 8..64.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 Operation  input  4  opcode: 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 LS, 10 RS.
REQ-007 a_operand  input  WIDTH  operand A, unsigned.
REQ-008 b_operand  input  WIDTH  operand B, unsigned.
REQ-009 out_valid  output  1  result registers hold an unconsumed result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 ALU_Output  output  WIDTH  registered result.
REQ-012 Exception  output  1  registered exception flag for the result.
REQ-013 Overflow  output  1  registered overflow/carry flag for the result.
REQ-014 busy  output  1  high while in MUL or DIV iteration.

Function
REQ-015 The FSM SHALL have states IDLE, MUL, DIV; MUL/DIV return to IDLE after the final iteration.
REQ-016 in_ready SHALL equal (state==IDLE) and (out_valid==0 or out_ready==1).
REQ-017 A request SHALL be accepted on a rising edge with in_valid and in_ready both high; operands and opcode are captured at that edge.
REQ-018 Single-cycle ops (ADD, SUB, AND, OR, XOR, NOT, LS, RS, undefined opcodes, DIV by zero) SHALL load results and set out_valid at the accepting edge.
REQ-019 MUL SHALL be iterative shift-add, one bit per cycle, result and out_valid loaded at the WIDTH-th edge after acceptance.
REQ-020 DIV SHALL be restoring unsigned division, one quotient bit per cycle, quotient and out_valid loaded at the WIDTH-th edge after acceptance.
REQ-021 ADD: result a+b mod 2^WIDTH, Overflow = carry out; SUB: a-b mod 2^WIDTH, Overflow = borrow (a<b).
REQ-022 MUL: result = low WIDTH bits of product; Overflow = 1 when the high WIDTH bits are nonzero.
REQ-023 LS: a<<1, Overflow = a[WIDTH-1]; RS: a>>1, Overflow = a[0]; logic ops and NOT: Overflow = 0.
REQ-024 DIV with b_operand==0 SHALL give ALU_Output all ones, Exception=1, no iteration.
REQ-025 Undefined opcodes (0, 11-15) SHALL give ALU_Output 0, Exception=1, Overflow=0.
REQ-026 All other results SHALL have Exception=0.
REQ-027 out_valid SHALL clear on an edge with out_ready high unless a new single-cycle result loads at that edge; ALU_Output/flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 Simultaneous consume and accept SHALL be legal with no lost or duplicated result.
REQ-029 Operand and opcode inputs SHALL be ignored while busy is high.

Reset
REQ-030 On reset low: state=IDLE, out_valid=0, busy=0, ALU_Output=0, Exception=0, Overflow=0, iteration counter=0, immediately and independent of clk.
REQ-031 Reset asserted mid MUL/DIV SHALL abort the operation; no result is produced after release.
REQ-032 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-033 Macro SEQ_ALU_DIV_EN defined: DIV state and divider datapath SHALL be compiled in per REQ-020/024.
REQ-034 Macro SEQ_ALU_DIV_EN undefined: no divider logic; DIV SHALL be treated as an undefined opcode per REQ-025 (single-cycle, Exception=1).

Verification (WIDTH=8, SEQ_ALU_DIV_EN defined unless stated)
REQ-035 ADD 0xF0+0x20, out_ready=1 -> next cycle out_valid=1, ALU_Output=0x10, Overflow=1, Exception=0.
REQ-036 MUL 0x10*0x20 -> busy=1 for 8 cycles, in_ready=0 throughout, then ALU_Output=0x00, Overflow=1.
REQ-037 DIV 200/7 -> after 8 edges ALU_Output=0x1C; DIV 5/0 -> next cycle ALU_Output=0xFF, Exception=1.
REQ-038 XOR 0xAA^0x0F with out_ready=0 for 5 cycles -> ALU_Output=0xA5 held, in_ready=0; out_ready=1 with new NOT 0x0F pending -> back-to-back result 0xF0 next cycle.
REQ-039 Reset low at 4th MUL iteration, release -> out_valid=0, busy=0, in_ready=1, no result emitted.
REQ-040 SEQ_ALU_DIV_EN undefined: DIV 200/7 -> next cycle ALU_Output=0x00, Exception=1, busy never asserted.
